enclave_cmd_sequencer: RTL and testbench

- Host-side initiator for the enclave op controller.
- Buffers host commands (opcode + op1/op2/out base addresses) in a small FIFO.
- Issues each command to the controller as a one-cycle config pulse, then waits for the controller's sticky done before issuing the next.
- Provides response pulses, a completion counter and a watchdog timeout with error-hold state.

---
 rtl/enclave_cmd_sequencer_if.sv | 44 ++++
 rtl/enclave_cmd_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_enclave_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/enclave_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// enclave_cmd_sequencer_if
//   Host command channel into the enclave command sequencer.
//
//   Signals:
//     cmd_valid     host -> seq  command valid
//     cmd_ready     seq  -> host command FIFO can accept (not full)
//     cmd_opcode    host -> seq  ENCRYPT/DECRYPT/ADD/MULT
//     cmd_op1_addr  host -> seq  operand 1 base address
//     cmd_op2_addr  host -> seq  operand 2 base address
//     cmd_out_addr  host -> seq  output base address
//
//   Modports:
//     master  host side (drives the command, observes ready)
//     slave   sequencer side (accepts the command, drives ready)
// ----------------------------------------------------------------------------
interface enclave_cmd_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_opcode;
    logic [ADDR_WIDTH-1:0] cmd_op1_addr;
    logic [ADDR_WIDTH-1:0] cmd_op2_addr;
    logic [ADDR_WIDTH-1:0] cmd_out_addr;

    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_op1_addr,
        output cmd_op2_addr,
        output cmd_out_addr,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_op1_addr,
        input  cmd_op2_addr,
        input  cmd_out_addr,
        output cmd_ready
    );
endinterface

// File: rtl/enclave_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// enclave_cmd_sequencer
//   Host-side initiator for the enclave op controller. Host commands are
//   buffered in a small FIFO and issued one at a time to the controller as a
//   single-cycle config_en pulse; the next command is only issued after the
//   controller's sticky done has been seen in BUSY. A watchdog moves the
//   sequencer into an error-hold state if done never arrives.
//
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     host (slave)      cmd_valid/cmd_ready/cmd_opcode/cmd_op*_addr channel
//     opcode            opcode of the last issued command (to controller)
//     config_en         one-cycle config strobe (to controller)
//     op1/op2/out_base_addr  base addresses of the last issued command
//     done              sticky completion from controller
//     busy              sequencer not IDLE
//     resp_valid        one-cycle pulse per completed command
//     resp_opcode       opcode of the most recently completed command
//     completed_count   completed commands, wraps
//     timeout_err       sticky watchdog error
//     err_clear         leaves ERROR and clears timeout_err
// ----------------------------------------------------------------------------
module enclave_cmd_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned FIFO_PTR_WIDTH = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMER_WIDTH    = 11,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,

    enclave_cmd_sequencer_if.slave host,

    output logic [1:0]             opcode,
    output logic                   config_en,
    output logic [ADDR_WIDTH-1:0]  op1_base_addr,
    output logic [ADDR_WIDTH-1:0]  op2_base_addr,
    output logic [ADDR_WIDTH-1:0]  out_base_addr,
    input  logic                   done,

    output logic                   busy,
    output logic                   resp_valid,
    output logic [1:0]             resp_opcode,
    output logic [COUNT_WIDTH-1:0] completed_count,
    output logic                   timeout_err,
    input  logic                   err_clear
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [1:0]            opc;
        logic [ADDR_WIDTH-1:0] op1;
        logic [ADDR_WIDTH-1:0] op2;
        logic [ADDR_WIDTH-1:0] out;
    } cmd_t;

    localparam logic [FIFO_PTR_WIDTH:0] DEPTH_CNT  = (FIFO_PTR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [TIMER_WIDTH-1:0]  TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t state;
    state_t state_nxt;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t                    fifo_mem [FIFO_DEPTH];
    logic [FIFO_PTR_WIDTH-1:0] wr_ptr;
    logic [FIFO_PTR_WIDTH-1:0] rd_ptr;
    logic [FIFO_PTR_WIDTH:0]   fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    cmd_t                      wr_cmd;
    cmd_t                      head;

    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign fifo_empty = (fifo_count == '0);

    // Ready looks only at full, so a same-cycle pop never frees a slot early.
    assign host.cmd_ready = !fifo_full;
    assign push           = host.cmd_valid && !fifo_full;

    assign wr_cmd = '{opc: host.cmd_opcode,
                      op1: host.cmd_op1_addr,
                      op2: host.cmd_op2_addr,
                      out: host.cmd_out_addr};
    assign head   = fifo_mem[rd_ptr];

    // Storage needs no reset: entries are only read once the count says so.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [TIMER_WIDTH-1:0] timer;
    logic                   timer_last;
    logic                   timer_clr;
    logic                   timer_inc;
    logic                   complete;
    logic                   timeout;
    logic                   clear_err;

    assign timer_last = (timer == TIMER_LAST);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // done is deliberately ignored outside BUSY: during ISSUE it still holds
    // the previous command's sticky value, and in ERROR the op is abandoned.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        clear_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_clr = 1'b1;
                state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (done) begin
                    complete  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (timer_last) begin
                    timeout   = 1'b1;
                    state_nxt = S_ERROR;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_ERROR: begin
                if (err_clear) begin
                    clear_err = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, watchdog and completion bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode          <= '0;
            config_en       <= 1'b0;
            op1_base_addr   <= '0;
            op2_base_addr   <= '0;
            out_base_addr   <= '0;
            resp_valid      <= 1'b0;
            resp_opcode     <= '0;
            completed_count <= '0;
            timeout_err     <= 1'b0;
            timer           <= '0;
        end else begin
            // A load only happens from IDLE and always lands in ISSUE, so the
            // strobe is high for exactly the ISSUE cycle.
            config_en  <= pop;
            resp_valid <= complete;

            if (pop) begin
                opcode        <= head.opc;
                op1_base_addr <= head.op1;
                op2_base_addr <= head.op2;
                out_base_addr <= head.out;
            end

            if (complete) begin
                resp_opcode     <= opcode;
                completed_count <= completed_count + 1'b1;
            end

            if (timeout) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end

            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_enclave_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_enclave_cmd_sequencer
//   Directed bench for enclave_cmd_sequencer. Instance dut uses the default
//   watchdog; instance dut_t uses an 8-cycle watchdog for the timeout cases.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_enclave_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    enclave_cmd_sequencer_if #(.ADDR_WIDTH(10)) ha ();
    enclave_cmd_sequencer_if #(.ADDR_WIDTH(10)) ht ();

    logic [1:0]  opcode_a, resp_opcode_a, opcode_t, resp_opcode_t;
    logic        config_en_a, busy_a, resp_valid_a, timeout_err_a, done_a, err_clear_a;
    logic        config_en_t, busy_t, resp_valid_t, timeout_err_t, done_t, err_clear_t;
    logic [9:0]  op1_a, op2_a, out_a, op1_t, op2_t, out_t;
    logic [15:0] count_a, count_t;

    enclave_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .host(ha),
        .opcode(opcode_a), .config_en(config_en_a),
        .op1_base_addr(op1_a), .op2_base_addr(op2_a), .out_base_addr(out_a),
        .done(done_a), .busy(busy_a), .resp_valid(resp_valid_a),
        .resp_opcode(resp_opcode_a), .completed_count(count_a),
        .timeout_err(timeout_err_a), .err_clear(err_clear_a)
    );

    enclave_cmd_sequencer #(.TIMEOUT_CYCLES(8), .TIMER_WIDTH(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .host(ht),
        .opcode(opcode_t), .config_en(config_en_t),
        .op1_base_addr(op1_t), .op2_base_addr(op2_t), .out_base_addr(out_t),
        .done(done_t), .busy(busy_t), .resp_valid(resp_valid_t),
        .resp_opcode(resp_opcode_t), .completed_count(count_t),
        .timeout_err(timeout_err_t), .err_clear(err_clear_t)
    );

    // Opcodes: ENCRYPT=0, DECRYPT=1, ADD=2, MULT=3
    logic [1:0] opc_tab [6] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3};

    function automatic logic [9:0] a1(input int i); return 10'(32'h100 + i); endfunction
    function automatic logic [9:0] a2(input int i); return 10'(32'h200 + i); endfunction
    function automatic logic [9:0] a3(input int i); return 10'(32'h300 + i); endfunction

    task automatic set_cmd_a(input int i);
        ha.cmd_opcode   = opc_tab[i];
        ha.cmd_op1_addr = a1(i);
        ha.cmd_op2_addr = a2(i);
        ha.cmd_out_addr = a3(i);
    endtask

    task automatic idle_inputs();
        ha.cmd_valid = 1'b0; ha.cmd_opcode = '0;
        ha.cmd_op1_addr = '0; ha.cmd_op2_addr = '0; ha.cmd_out_addr = '0;
        ht.cmd_valid = 1'b0; ht.cmd_opcode = '0;
        ht.cmd_op1_addr = '0; ht.cmd_op2_addr = '0; ht.cmd_out_addr = '0;
        done_a = 1'b0; err_clear_a = 1'b0;
        done_t = 1'b0; err_clear_t = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++; if (config_en_a !== 1'b0) begin errors++; $display("FAIL rst_config_en got %0h exp 0", config_en_a); end
        checks++; if (opcode_a !== 2'd0) begin errors++; $display("FAIL rst_opcode got %0h exp 0", opcode_a); end
        checks++; if ({op1_a, op2_a, out_a} !== 30'd0) begin errors++; $display("FAIL rst_addrs got %0h/%0h/%0h exp 0", op1_a, op2_a, out_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", busy_a); end
        checks++; if (ha.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %0h exp 1", ha.cmd_ready); end
        checks++; if ({resp_valid_a, resp_opcode_a, count_a, timeout_err_a} !== 20'd0) begin errors++; $display("FAIL rst_resp got rv=%0h ro=%0h cnt=%0h to=%0h exp 0", resp_valid_a, resp_opcode_a, count_a, timeout_err_a); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int stray;
        do_reset();
        ha.cmd_valid = 1'b1; ha.cmd_opcode = 2'd2;
        ha.cmd_op1_addr = 10'h010; ha.cmd_op2_addr = 10'h020; ha.cmd_out_addr = 10'h030;
        done_a = 1'b1;                   // stale sticky done from an earlier op
        @(negedge clk);
        ha.cmd_valid = 1'b0;
        checks++; if (config_en_a !== 1'b0) begin errors++; $display("FAIL basic_cfg_early got %0h exp 0", config_en_a); end
        @(negedge clk);
        checks++; if (config_en_a !== 1'b1) begin errors++; $display("FAIL basic_cfg_pulse got %0h exp 1", config_en_a); end
        checks++; if (opcode_a !== 2'd2) begin errors++; $display("FAIL basic_opcode got %0h exp 2", opcode_a); end
        checks++; if ({op1_a, op2_a, out_a} !== {10'h010, 10'h020, 10'h030}) begin errors++; $display("FAIL basic_addrs got %0h/%0h/%0h exp 10/20/30", op1_a, op2_a, out_a); end
        @(negedge clk);
        // done stayed high across the ISSUE edge; it must not complete the op
        checks++; if ({config_en_a, resp_valid_a, busy_a} !== 3'b001) begin errors++; $display("FAIL basic_stale_done got cfg=%0h rv=%0h busy=%0h exp 0/0/1", config_en_a, resp_valid_a, busy_a); end
        done_a = 1'b0;
        stray = 0;
        repeat (11) begin
            @(negedge clk);
            if (config_en_a || resp_valid_a || !busy_a) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL basic_wait_quiet got %0d events exp 0", stray); end
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        checks++; if (resp_valid_a !== 1'b1) begin errors++; $display("FAIL basic_resp_valid got %0h exp 1", resp_valid_a); end
        checks++; if (resp_opcode_a !== 2'd2) begin errors++; $display("FAIL basic_resp_opcode got %0h exp 2", resp_opcode_a); end
        checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", count_a); end
        @(negedge clk);
        checks++; if ({resp_valid_a, config_en_a, busy_a} !== 3'b000) begin errors++; $display("FAIL basic_after got rv=%0h cfg=%0h busy=%0h exp 0/0/0", resp_valid_a, config_en_a, busy_a); end
        checks++; if ({resp_opcode_a, opcode_a} !== {2'd2, 2'd2}) begin errors++; $display("FAIL basic_hold got ro=%0h op=%0h exp 2/2", resp_opcode_a, opcode_a); end
    endtask

    task automatic serve(input int k);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            @(negedge clk);
            if (config_en_a) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL serve_issue[%0d] got no config_en exp pulse", k); end
        checks++; if ({opcode_a, op1_a, op2_a, out_a} !== {opc_tab[k], a1(k), a2(k), a3(k)}) begin errors++; $display("FAIL serve_cmd[%0d] got %0h %0h %0h %0h exp %0h %0h %0h %0h", k, opcode_a, op1_a, op2_a, out_a, opc_tab[k], a1(k), a2(k), a3(k)); end
        @(negedge clk);
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        checks++; if ({resp_valid_a, resp_opcode_a} !== {1'b1, opc_tab[k]}) begin errors++; $display("FAIL serve_resp[%0d] got rv=%0h ro=%0h exp 1/%0h", k, resp_valid_a, resp_opcode_a, opc_tab[k]); end
        checks++; if (count_a !== 16'(k + 1)) begin errors++; $display("FAIL serve_count[%0d] got %0d exp %0d", k, count_a, k + 1); end
    endtask

    task automatic test_back_to_back();
        int stray;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++; if (ha.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %0h exp 1", i, ha.cmd_ready); end
            if (i == 2) begin
                checks++; if ({config_en_a, opcode_a} !== {1'b1, opc_tab[0]}) begin errors++; $display("FAIL b2b_first_issue got cfg=%0h op=%0h exp 1/%0h", config_en_a, opcode_a, opc_tab[0]); end
            end
            ha.cmd_valid = 1'b1;
            set_cmd_a(i);
            @(negedge clk);
        end
        checks++; if (ha.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %0h exp 0", ha.cmd_ready); end
        set_cmd_a(5);                    // sixth command held valid while full
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        checks++; if ({resp_valid_a, resp_opcode_a} !== {1'b1, opc_tab[0]}) begin errors++; $display("FAIL b2b_resp0 got rv=%0h ro=%0h exp 1/%0h", resp_valid_a, resp_opcode_a, opc_tab[0]); end
        // This cycle pops; ready must still reflect the full FIFO
        checks++; if (ha.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %0h exp 0", ha.cmd_ready); end
        @(negedge clk);
        checks++; if (ha.cmd_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready_after got %0h exp 1", ha.cmd_ready); end
        checks++; if ({config_en_a, opcode_a, op1_a} !== {1'b1, opc_tab[1], a1(1)}) begin errors++; $display("FAIL b2b_issue1 got cfg=%0h op=%0h a1=%0h exp 1/%0h/%0h", config_en_a, opcode_a, op1_a, opc_tab[1], a1(1)); end
        @(negedge clk);
        ha.cmd_valid = 1'b0;
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        checks++; if ({resp_valid_a, resp_opcode_a, count_a} !== {1'b1, opc_tab[1], 16'd2}) begin errors++; $display("FAIL b2b_resp1 got rv=%0h ro=%0h cnt=%0d exp 1/%0h/2", resp_valid_a, resp_opcode_a, count_a, opc_tab[1]); end
        for (int k = 2; k < 6; k++) serve(k);
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (config_en_a || busy_a) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL b2b_drained got %0d extra issues exp 0", stray); end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        ht.cmd_valid = 1'b1; ht.cmd_opcode = 2'd3;
        ht.cmd_op1_addr = 10'h0AA; ht.cmd_op2_addr = 10'h0BB; ht.cmd_out_addr = 10'h0CC;
        @(negedge clk);
        ht.cmd_opcode = 2'd1;
        ht.cmd_op1_addr = 10'h1A1; ht.cmd_op2_addr = 10'h1B1; ht.cmd_out_addr = 10'h1C1;
        @(negedge clk);
        ht.cmd_valid = 1'b0;
        checks++; if ({config_en_t, opcode_t} !== {1'b1, 2'd3}) begin errors++; $display("FAIL to_issue got cfg=%0h op=%0h exp 1/3", config_en_t, opcode_t); end
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (timeout_err_t || !busy_t || config_en_t) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_early got %0d bad cycles exp 0", bad); end
        @(negedge clk);
        checks++; if ({timeout_err_t, busy_t} !== 2'b11) begin errors++; $display("FAIL to_err_rise got err=%0h busy=%0h exp 1/1", timeout_err_t, busy_t); end
        done_t = 1'b1;                   // late done in ERROR is ignored
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (config_en_t || resp_valid_t || !timeout_err_t) bad++;
        end
        done_t = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_err_hold got %0d bad cycles exp 0", bad); end
        checks++; if (count_t !== 16'd0) begin errors++; $display("FAIL to_no_count got %0d exp 0", count_t); end
        err_clear_t = 1'b1;
        @(negedge clk);
        err_clear_t = 1'b0;
        checks++; if ({timeout_err_t, config_en_t, busy_t} !== 3'b000) begin errors++; $display("FAIL to_clear got err=%0h cfg=%0h busy=%0h exp 0/0/0", timeout_err_t, config_en_t, busy_t); end
        @(negedge clk);
        checks++; if ({config_en_t, opcode_t, op1_t} !== {1'b1, 2'd1, 10'h1A1}) begin errors++; $display("FAIL to_next_issue got cfg=%0h op=%0h a1=%0h exp 1/1/1a1", config_en_t, opcode_t, op1_t); end
    endtask

    // Continues from the ISSUE cycle reached at the end of test_timeout.
    task automatic test_done_at_terminal();
        repeat (8) @(negedge clk);
        checks++; if ({timeout_err_t, busy_t} !== 2'b01) begin errors++; $display("FAIL term_pre got err=%0h busy=%0h exp 0/1", timeout_err_t, busy_t); end
        done_t = 1'b1;
        @(negedge clk);
        done_t = 1'b0;
        checks++; if ({resp_valid_t, resp_opcode_t, timeout_err_t} !== {1'b1, 2'd1, 1'b0}) begin errors++; $display("FAIL term_done_wins got rv=%0h ro=%0h err=%0h exp 1/1/0", resp_valid_t, resp_opcode_t, timeout_err_t); end
        checks++; if ({count_t, busy_t} !== {16'd1, 1'b0}) begin errors++; $display("FAIL term_count got cnt=%0d busy=%0h exp 1/0", count_t, busy_t); end
    endtask

    task automatic test_async_reset();
        int stray;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ha.cmd_valid = 1'b1;
            set_cmd_a(i);
            @(negedge clk);
        end
        ha.cmd_valid = 1'b0;
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        @(negedge clk);
        checks++; if ({config_en_a, count_a} !== {1'b1, 16'd1}) begin errors++; $display("FAIL ar_setup got cfg=%0h cnt=%0d exp 1/1", config_en_a, count_a); end
        @(negedge clk);
        #2 rst_n = 1'b0;                 // mid-BUSY, between clock edges
        #1;
        checks++; if ({config_en_a, opcode_a, op1_a, op2_a, out_a} !== 33'd0) begin errors++; $display("FAIL ar_cmd_outs got cfg=%0h op=%0h %0h/%0h/%0h exp 0", config_en_a, opcode_a, op1_a, op2_a, out_a); end
        checks++; if ({resp_valid_a, resp_opcode_a, count_a, timeout_err_a} !== 20'd0) begin errors++; $display("FAIL ar_resp_outs got rv=%0h ro=%0h cnt=%0d err=%0h exp 0", resp_valid_a, resp_opcode_a, count_a, timeout_err_a); end
        checks++; if ({busy_a, ha.cmd_ready} !== 2'b01) begin errors++; $display("FAIL ar_busy_ready got busy=%0h rdy=%0h exp 0/1", busy_a, ha.cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (config_en_a || resp_valid_a || busy_a) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL ar_discarded got %0d events exp 0", stray); end
        ha.cmd_valid = 1'b1;
        set_cmd_a(3);
        @(negedge clk);
        ha.cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if ({config_en_a, opcode_a, out_a} !== {1'b1, opc_tab[3], a3(3)}) begin errors++; $display("FAIL ar_new_issue got cfg=%0h op=%0h out=%0h exp 1/%0h/%0h", config_en_a, opcode_a, out_a, opc_tab[3], a3(3)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_done_at_terminal();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got no finish exp finish before 200000");
        $fatal(1, "time limit");
    end

endmodule
